stump_result_commit: RTL and testbench

- Write-back/commit stage directly downstream of the Stump ALU.
- Captures the ALU result and NZVC flags, and holds the condition-code register. It feeds the carry back to the ALU `c_in` and evaluates branch conditions.
- Queues ALU results in a small FIFO and drains them to the register-file write port. Load-data returns share this port and have priority over the queue.

---
 rtl/stump_result_commit.sv | 150 +++++++++++++++
 tb/tb_stump_result_commit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stump_result_commit.sv
// Stump write-back/commit stage: result FIFO, CC register, branch evaluation and RF write port.
// Optional macro STUMP_CC_FORWARD_EN forwards accepted ALU flags to br_taken/c_flag in the same cycle.
module stump_result_commit #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic [3:0]               alu_flags,
    input  logic [2:0]               alu_dest,
    input  logic                     alu_set_cc,
    input  logic                     ld_valid,
    input  logic [WIDTH-1:0]         ld_data,
    input  logic [2:0]               ld_dest,
    output logic                     rf_we,
    output logic [2:0]               rf_waddr,
    output logic [WIDTH-1:0]         rf_wdata,
    output logic [3:0]               cc,
    output logic                     c_flag,
    input  logic [3:0]               br_cond,
    output logic                     br_taken,
    output logic [7:0]               pend_mask,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2:0]       r_addr [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic [3:0]       r_cc;
    logic             r_rfWe;
    logic [2:0]       r_rfWaddr;
    logic [WIDTH-1:0] r_rfWdata;

    logic             w_accept;
    logic             w_push;
    logic             w_ldWin;
    logic             w_pop;
    logic [3:0]       w_flags;
    logic [7:0]       w_pend;
    logic             w_taken;

    // Ready deliberately ignores a same-cycle pop: a full FIFO never passes through.
    assign alu_ready = (r_count < CW'(DEPTH)) && !rst;
    assign w_accept  = alu_valid && alu_ready;
    assign w_push    = w_accept && (alu_dest != 3'd0);
    assign w_ldWin   = ld_valid && (ld_dest != 3'd0);
    assign w_pop     = !w_ldWin && (r_count != '0);

`ifdef STUMP_CC_FORWARD_EN
    assign w_flags = (w_accept && alu_set_cc) ? alu_flags : r_cc;
`else
    assign w_flags = r_cc;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld     <= '0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_cc      <= 4'd0;
            r_rfWe    <= 1'b0;
            r_rfWaddr <= 3'd0;
            r_rfWdata <= '0;
        end else begin
            if (w_accept && alu_set_cc) begin
                r_cc <= alu_flags;
            end
            if (w_push) begin
                r_addr[r_wrPtr] <= alu_dest;
                r_data[r_wrPtr] <= alu_result;
                r_vld[r_wrPtr]  <= 1'b1;
                r_wrPtr         <= r_wrPtr + PW'(1);
            end
            if (w_pop) begin
                r_vld[r_rdPtr] <= 1'b0;
                r_rdPtr        <= r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // Load returns own the write port; the queue only drains when no load claims it.
            if (w_ldWin) begin
                r_rfWe    <= 1'b1;
                r_rfWaddr <= ld_dest;
                r_rfWdata <= ld_data;
            end else if (w_pop) begin
                r_rfWe    <= 1'b1;
                r_rfWaddr <= r_addr[r_rdPtr];
                r_rfWdata <= r_data[r_rdPtr];
            end else begin
                r_rfWe    <= 1'b0;
            end
        end
    end

    always_comb begin
        w_pend = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_pend = w_pend | (8'b1 << r_addr[i]);
            end
        end
    end

    // Flags are {N,Z,V,C}.
    always_comb begin
        w_taken = 1'b0;
        case (br_cond)
            4'd0:  w_taken = 1'b1;
            4'd1:  w_taken = 1'b0;
            4'd2:  w_taken = !w_flags[0] && !w_flags[2];
            4'd3:  w_taken = w_flags[0] || w_flags[2];
            4'd4:  w_taken = !w_flags[0];
            4'd5:  w_taken = w_flags[0];
            4'd6:  w_taken = !w_flags[2];
            4'd7:  w_taken = w_flags[2];
            4'd8:  w_taken = !w_flags[1];
            4'd9:  w_taken = w_flags[1];
            4'd10: w_taken = !w_flags[3];
            4'd11: w_taken = w_flags[3];
            4'd12: w_taken = (w_flags[3] == w_flags[1]);
            4'd13: w_taken = (w_flags[3] != w_flags[1]);
            4'd14: w_taken = !w_flags[2] && (w_flags[3] == w_flags[1]);
            4'd15: w_taken = w_flags[2] || (w_flags[3] != w_flags[1]);
            default: w_taken = 1'b0;
        endcase
    end

    assign br_taken  = w_taken;
    assign c_flag    = w_flags[0];
    assign cc        = r_cc;
    assign pend_mask = w_pend;
    assign count     = r_count;
    assign rf_we     = r_rfWe;
    assign rf_waddr  = r_rfWaddr;
    assign rf_wdata  = r_rfWdata;

endmodule

// File: tb/tb_stump_result_commit.sv
// Self-checking bench for stump_result_commit: write scoreboard, hand sequences and a
// table-driven branch-condition sweep.
module tb_stump_result_commit;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [15:0] alu_result;
    logic [3:0]  alu_flags;
    logic [2:0]  alu_dest;
    logic        alu_set_cc;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic [2:0]  ld_dest;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [3:0]  cc;
    logic        c_flag;
    logic [3:0]  br_cond;
    logic        br_taken;
    logic [7:0]  pend_mask;
    logic [1:0]  count;

    int checks = 0;
    int errors = 0;

    logic [18:0] expQ [$];

    typedef struct {
        logic [3:0]  ccVal;
        logic [15:0] takenMask;
    } condVec_t;

    condVec_t vecs [5];

    stump_result_commit #(.DEPTH(2), .WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .alu_dest   (alu_dest),
        .alu_set_cc (alu_set_cc),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_dest    (ld_dest),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .cc         (cc),
        .c_flag     (c_flag),
        .br_cond    (br_cond),
        .br_taken   (br_taken),
        .pend_mask  (pend_mask),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic aV, input logic [15:0] aRes, input logic [3:0] aFl,
                                 input logic [2:0] aDst, input logic aCc,
                                 input logic lV, input logic [15:0] lD, input logic [2:0] lDst);
        alu_valid  = aV;
        alu_result = aRes;
        alu_flags  = aFl;
        alu_dest   = aDst;
        alu_set_cc = aCc;
        ld_valid   = lV;
        ld_data    = lD;
        ld_dest    = lDst;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b0, 16'h0, 3'd0);
    endtask

    // Every cycle the write port fires must match the next predicted write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", {13'd0, rf_waddr, rf_wdata}, 32'd0);
            end else begin
                logic [18:0] e;
                e = expQ.pop_front();
                checkOutput("wr_addr", 32'(rf_waddr), 32'(e[18:16]));
                checkOutput("wr_data", 32'(rf_wdata), 32'(e[15:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{4'b0000, 16'h5555};
        vecs[1] = '{4'b0100, 16'h9599};
        vecs[2] = '{4'b0001, 16'h5569};
        vecs[3] = '{4'b1010, 16'h5A55};
        vecs[4] = '{4'b0010, 16'hA655};

        rst = 1'b1;
        br_cond = 4'd0;
        idle();
        tick();
        tick();
        checkOutput("rst_ready",  32'(alu_ready), 32'd0);
        checkOutput("rst_count",  32'(count), 32'd0);
        checkOutput("rst_cc",     32'(cc), 32'd0);
        checkOutput("rst_we",     32'(rf_we), 32'd0);
        checkOutput("rst_waddr",  32'(rf_waddr), 32'd0);
        checkOutput("rst_wdata",  32'(rf_wdata), 32'd0);
        checkOutput("rst_pend",   32'(pend_mask), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_rst", 32'(alu_ready), 32'd1);

        // Single op to R3 with CC update.
        applyStimulus(1'b1, 16'h8000, 4'b1000, 3'd3, 1'b1, 1'b0, 16'h0, 3'd0);
        expQ.push_back({3'd3, 16'h8000});
        tick();
        idle();
        checkOutput("single_cc",    32'(cc), 32'h8);
        checkOutput("single_count", 32'(count), 32'd1);
        checkOutput("single_pend",  32'(pend_mask), 32'h08);
        checkOutput("single_we0",   32'(rf_we), 32'd0);
        br_cond = 4'd11;
        #1;
        checkOutput("single_MI", 32'(br_taken), 32'd1);
        br_cond = 4'd10;
        #1;
        checkOutput("single_PL", 32'(br_taken), 32'd0);
        tick();
        checkOutput("single_we",    32'(rf_we), 32'd1);
        checkOutput("single_waddr", 32'(rf_waddr), 32'd3);
        checkOutput("single_wdata", 32'(rf_wdata), 32'h8000);
        checkOutput("single_drain", 32'(count), 32'd0);
        tick();
        checkOutput("single_we_off",  32'(rf_we), 32'd0);
        checkOutput("hold_waddr",     32'(rf_waddr), 32'd3);
        checkOutput("hold_wdata",     32'(rf_wdata), 32'h8000);

        // R0 destination: CC updates, nothing queued, loads to R0 dropped.
        applyStimulus(1'b1, 16'hFFFF, 4'b0001, 3'd0, 1'b1, 1'b0, 16'h0, 3'd0);
        tick();
        idle();
        checkOutput("r0_count", 32'(count), 32'd0);
        checkOutput("r0_cflag", 32'(c_flag), 32'd1);
        checkOutput("r0_cc",    32'(cc), 32'h1);
        checkOutput("r0_pend",  32'(pend_mask), 32'd0);
        applyStimulus(1'b0, 16'h0, 4'h0, 3'd0, 1'b0, 1'b1, 16'h1234, 3'd0);
        tick();
        idle();
        checkOutput("r0_ld_we", 32'(rf_we), 32'd0);
        tick();
        checkOutput("r0_ld_we2", 32'(rf_we), 32'd0);

        // Load priority over a queued R4 result.
        applyStimulus(1'b1, 16'h00AA, 4'h0, 3'd4, 1'b0, 1'b1, 16'h5555, 3'd5);
        for (int i = 0; i < 3; i++) begin
            expQ.push_back({3'd5, 16'h5555});
            tick();
            alu_valid = 1'b0;
            checkOutput("ld_pend4", 32'(pend_mask[4]), 32'd1);
            checkOutput("ld_count", 32'(count), 32'd1);
        end
        idle();
        expQ.push_back({3'd4, 16'h00AA});
        tick();
        checkOutput("ld_pend_clr", 32'(pend_mask), 32'd0);
        checkOutput("ld_r4_addr",  32'(rf_waddr), 32'd4);
        tick();

        // Full FIFO with load held: backpressure keeps CC unchanged.
        applyStimulus(1'b1, 16'h0101, 4'h0, 3'd1, 1'b0, 1'b1, 16'h6666, 3'd6);
        expQ.push_back({3'd6, 16'h6666});
        tick();
        alu_result = 16'h0202;
        alu_dest   = 3'd2;
        expQ.push_back({3'd6, 16'h6666});
        tick();
        checkOutput("full_count", 32'(count), 32'd2);
        checkOutput("full_ready", 32'(alu_ready), 32'd0);
        checkOutput("full_pend",  32'(pend_mask), 32'h06);
        applyStimulus(1'b1, 16'h0303, 4'b0100, 3'd3, 1'b1, 1'b1, 16'h6666, 3'd6);
        for (int i = 0; i < 2; i++) begin
            expQ.push_back({3'd6, 16'h6666});
            tick();
            checkOutput("full_cc_hold", 32'(cc), 32'h1);
            checkOutput("full_count_hold", 32'(count), 32'd2);
        end
        ld_valid = 1'b0;
        expQ.push_back({3'd1, 16'h0101});
        tick();
        checkOutput("nopass_cc",    32'(cc), 32'h1);
        checkOutput("nopass_count", 32'(count), 32'd1);
        checkOutput("nopass_ready", 32'(alu_ready), 32'd1);
        expQ.push_back({3'd2, 16'h0202});
        tick();
        idle();
        checkOutput("pushpop_cc",    32'(cc), 32'h4);
        checkOutput("pushpop_count", 32'(count), 32'd1);
        checkOutput("pushpop_pend",  32'(pend_mask), 32'h08);
        expQ.push_back({3'd3, 16'h0303});
        tick();
        checkOutput("full_drain", 32'(count), 32'd0);
        tick();
        checkOutput("full_idle_we", 32'(rf_we), 32'd0);

        // Reset while draining: R2 entry must never be written.
        applyStimulus(1'b1, 16'h1111, 4'h0, 3'd1, 1'b0, 1'b0, 16'h0, 3'd0);
        expQ.push_back({3'd1, 16'h1111});
        tick();
        alu_result = 16'h2222;
        alu_dest   = 3'd2;
        tick();
        idle();
        rst = 1'b1;
        #1;
        checkOutput("rstmid_ready", 32'(alu_ready), 32'd0);
        tick();
        rst = 1'b0;
        checkOutput("rstmid_count", 32'(count), 32'd0);
        checkOutput("rstmid_pend",  32'(pend_mask), 32'd0);
        checkOutput("rstmid_we",    32'(rf_we), 32'd0);
        checkOutput("rstmid_cc",    32'(cc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rstmid_no_write", 32'(rf_we), 32'd0);
        end

        // Condition-code sweep over all branch conditions.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(1'b1, 16'h0, vecs[v].ccVal, 3'd0, 1'b1, 1'b0, 16'h0, 3'd0);
            tick();
            idle();
            checkOutput("sweep_cc", 32'(cc), 32'(vecs[v].ccVal));
            for (int k = 0; k < 16; k++) begin
                br_cond = 4'(k);
                #1;
                if (br_taken !== vecs[v].takenMask[k]) begin
                    $display("[TB] cc=%b br_cond=%0d", vecs[v].ccVal, k);
                end
                checkOutput("sweep_taken", 32'(br_taken), 32'(vecs[v].takenMask[k]));
            end
        end

        tick();
        tick();
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
